// File: rtl/seq_mul_unit.sv
// Sequential shift-add multiplier (signed/unsigned), one multiplier bit per cycle.
// Optional early termination when the remaining multiplier bits are zero: define SEQ_MUL_EARLY_OUT_EN.
module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 is_unsign,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, mcand, acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic               finish;

  // Magnitude of a two's-complement operand; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    if (is_signed && sv[WIDTH-1])
      return unsigned'(-sv);
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign(input logic [2*WIDTH-1:0] v, input logic negate);
    return negate ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MUL_EARLY_OUT_EN
  assign finish = (count == LAST) || ((mplier >> 1) == '0);
`else
  assign finish = (count == LAST);
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = BUSY;
      BUSY: begin
        if (!enable)     state_next = IDLE;
        else if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == BUSY) && (state_next == DONE);
      // Capture stage: operand magnitudes and product sign
      if (state == IDLE && enable) begin
        mcand  <= {{WIDTH{1'b0}}, magnitude(a, !is_unsign)};
        mplier <= magnitude(b, !is_unsign);
        neg    <= !is_unsign && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        count  <= '0;
      end
      // Iteration stage: one multiplier bit per cycle, result loaded on the last one
      if (state == BUSY && enable) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
        if (finish)
          result <= fix_sign(acc_sum, neg);
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: directed vector table, corner sequences, randomized
// operands against an arithmetic product/latency model. Works with or without SEQ_MUL_EARLY_OUT_EN.
module tb_seq_mul_unit;
  localparam int WIDTH = 32;
`ifdef SEQ_MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic               sys_clk = 1'b0;
  logic               rst, enable, is_unsign;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] result;
  logic               done;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp = '0;

  seq_mul_unit #(.WIDTH(WIDTH)) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .is_unsign(is_unsign),
    .a(a), .b(b), .result(result), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          uns;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference product from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit uns);
    logic signed [63:0] sx, sy;
    if (uns) return {32'b0, x} * {32'b0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    return sx * sy;
  endfunction

  // Cycle in which done is expected, counting the capture cycle as 0.
  function automatic int exp_lat(input logic [31:0] y, input bit uns);
    logic [31:0] m;
    int hi;
    m  = (!uns && y[31]) ? (~y + 32'd1) : y;
    hi = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hi = i + 1;
    if (hi < 1) hi = 1;
    return (EARLY ? hi : WIDTH) + 1;
  endfunction

  task automatic wait_done(input int lat, input logic [63:0] req, input string nm, input bit scramble);
    int n;
    n = 0;
    while (n < lat + 4) begin
      @(posedge sys_clk); n++; #1;
      if (scramble && n == 2) begin
        a = $urandom; b = $urandom; is_unsign = 1'($urandom_range(0, 1));
      end
      if (done) break;
    end
    check({nm, " done"}, 64'(done), 64'd1);
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " result"}, result, req);
    last_exp = req;
  endtask

  // Drop enable during DONE, then confirm the pulse ended and result is held.
  task automatic finish_op(input string nm);
    enable = 1'b0;
    @(posedge sys_clk); #1;
    check({nm, " pulse end"}, 64'(done), 64'd0);
    check({nm, " hold"}, result, last_exp);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit uns,
                        input logic [63:0] req, input string nm, input bit scramble);
    a = x; b = y; is_unsign = uns; enable = 1'b1;
    wait_done(exp_lat(y, uns), req, nm, scramble);
    finish_op(nm);
  endtask

  vec_t vecs[10];
  logic [31:0] long_b;
  logic [31:0] ra, rb;
  bit          ru;
  bit          seen;

  initial begin
    vecs[0] = '{32'd6,          32'd7,          1'b1, 64'h0000_0000_0000_002A};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'h0000_0000_0000_0001};
    vecs[3] = '{32'h8000_0000,  32'h8000_0000,  1'b0, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF,  32'd5,          1'b0, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[5] = '{32'd9,          32'd0,          1'b1, 64'h0};
    vecs[6] = '{32'd9,          32'd1,          1'b1, 64'd9};
    vecs[7] = '{32'h8000_0000,  32'd1,          1'b0, 64'hFFFF_FFFF_8000_0000};
    vecs[8] = '{32'h8000_0000,  32'd2,          1'b1, 64'h0000_0001_0000_0000};
    vecs[9] = '{32'd12345,      32'h8000_0000,  1'b1, 64'h0000_181C_8000_0000};

    rst = 1'b1; enable = 1'b0; is_unsign = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset result", result, 64'h0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b0;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].uns, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

    // Abort: enable low in BUSY cycle 10; FSM must be idle again at cycle 11.
    long_b = EARLY ? 32'h8000_0004 : 32'd4;
    a = 32'd3; b = long_b; is_unsign = 1'b1; enable = 1'b1;
    seen = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(posedge sys_clk); #1;
      if (done) seen = 1'b1;
      if (n == 10) enable = 1'b0;
    end
    check("abort no done", 64'(seen), 64'd0);
    check("abort hold", result, last_exp);
    run_op(32'd11, 32'd13, 1'b1, 64'd143, "after abort", 1'b0);

    // Reset at cycle 20 of an in-flight operation.
    a = 32'd7; b = long_b; is_unsign = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(posedge sys_clk); #1;
    end
    rst = 1'b1;
    @(posedge sys_clk); #1;
    check("midop rst result", result, 64'h0);
    check("midop rst done", 64'(done), 64'd0);
    rst = 1'b0; enable = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge sys_clk); #1;
      if (done) seen = 1'b1;
    end
    check("no done after rst", 64'(seen), 64'd0);
    last_exp = '0;

    // Back-to-back: operands switched during DONE with enable held.
    a = 32'd3; b = 32'd4; is_unsign = 1'b1; enable = 1'b1;
    wait_done(exp_lat(32'd4, 1'b1), 64'd12, "b2b first", 1'b0);
    a = 32'd5; b = 32'd6;
    wait_done(1 + exp_lat(32'd6, 1'b1), 64'd30, "b2b second", 1'b0);
    finish_op("b2b second");

    // Randomized operands, scrambled while busy to prove only captured values are used.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; ru = 1'($urandom_range(0, 1));
      case (i % 4)
        0: rb = rb & 32'h0000_00FF;
        1: ra = 32'h8000_0000;
        2: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(ra, rb, ru, model(ra, rb, ru), $sformatf("rand%0d", i), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
